key_load_ctrl: RTL and testbench

- Key-load sequencer placed in front of a key-locked FSM benchmark core.
- Accepts a serially delivered key with a trailing parity bit and checks it.
- Holds the core in reset until a valid key is loaded, then releases it and drives the key bus for the whole run.
- Counts consecutive failed loads (parity error or timeout); at the limit it locks the core out until reset.

---
 rtl/key_load_ctrl.sv | 150 +++++++++++++++
 tb/tb_key_load_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/key_load_ctrl.sv
// Key-load sequencer: receives a serial key plus even-parity bit, holds the
// locked core in reset until a checked key is on key_out, and locks out after repeated failures.
module key_load_ctrl #(
  parameter int KEY_W    = 8,
  parameter int LOAD_TO  = 64,
  parameter int MAX_FAIL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_req,
  input  logic             key_sdi,
  input  logic             key_sdi_vld,
  output logic             core_rst,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             load_ack,
  output logic             busy,
  output logic             par_err,
  output logic             timeout_err,
  output logic             lockout
);

  localparam int TW = $clog2(LOAD_TO + 1);
  localparam int CW = $clog2(KEY_W + 2);
  localparam int FW = $clog2(MAX_FAIL + 1);

  localparam logic [CW-1:0] LAST_BIT = CW'(KEY_W);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOAD_TO - 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_CHECK, S_RELEASE, S_RUN, S_LOCK
  } state_t;

  state_t           state, state_nxt;
  logic [KEY_W:0]   shreg, shreg_nxt;
  logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic [FW-1:0]    fail_cnt, fail_nxt, fail_inc;
  logic [KEY_W-1:0] key_out_nxt;
  logic             key_valid_nxt, load_ack_nxt, par_err_nxt, timeout_nxt;

  assign fail_inc = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 1'b1;
  assign busy     = (state == S_SHIFT) || (state == S_CHECK);

  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    bit_cnt_nxt   = bit_cnt;
    timer_nxt     = timer;
    fail_nxt      = fail_cnt;
    key_out_nxt   = key_out;
    key_valid_nxt = key_valid;
    load_ack_nxt  = 1'b0;
    par_err_nxt   = 1'b0;
    timeout_nxt   = 1'b0;

    case (state)
      S_IDLE: begin
        if (load_req) begin
          state_nxt   = S_SHIFT;
          shreg_nxt   = '0;
          bit_cnt_nxt = '0;
          timer_nxt   = '0;
        end
      end
      S_SHIFT: begin
        if (key_sdi_vld) begin
          shreg_nxt[bit_cnt] = key_sdi;
          bit_cnt_nxt        = bit_cnt + 1'b1;
          timer_nxt          = '0;
          if (bit_cnt == LAST_BIT) state_nxt = S_CHECK;
        end else if (timer == TO_LAST) begin
          // LOAD_TO consecutive idle cycles: abandon the frame
          timeout_nxt = 1'b1;
          fail_nxt    = fail_inc;
          state_nxt   = (fail_inc == FAIL_MAX) ? S_LOCK : S_IDLE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_CHECK: begin
        if (^shreg == 1'b0) begin
          key_out_nxt   = shreg[KEY_W-1:0];
          key_valid_nxt = 1'b1;
          load_ack_nxt  = 1'b1;
          fail_nxt      = '0;
          state_nxt     = S_RELEASE;
        end else begin
          par_err_nxt = 1'b1;
          fail_nxt    = fail_inc;
          state_nxt   = (fail_inc == FAIL_MAX) ? S_LOCK : S_IDLE;
        end
      end
      S_RELEASE: state_nxt = S_RUN;
      S_RUN: begin
        if (load_req) begin
          state_nxt     = S_SHIFT;
          key_out_nxt   = '0;
          key_valid_nxt = 1'b0;
          shreg_nxt     = '0;
          bit_cnt_nxt   = '0;
          timer_nxt     = '0;
        end
      end
      S_LOCK: begin
        key_out_nxt   = '0;
        key_valid_nxt = 1'b0;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (state_nxt == S_LOCK) begin
      key_out_nxt   = '0;
      key_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      timer       <= '0;
      fail_cnt    <= '0;
      core_rst    <= 1'b1;
      key_out     <= '0;
      key_valid   <= 1'b0;
      load_ack    <= 1'b0;
      par_err     <= 1'b0;
      timeout_err <= 1'b0;
      lockout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      bit_cnt     <= bit_cnt_nxt;
      timer       <= timer_nxt;
      fail_cnt    <= fail_nxt;
      // core stays in reset everywhere but RUN, aligned with the state register
      core_rst    <= (state_nxt != S_RUN);
      key_out     <= key_out_nxt;
      key_valid   <= key_valid_nxt;
      load_ack    <= load_ack_nxt;
      par_err     <= par_err_nxt;
      timeout_err <= timeout_nxt;
      lockout     <= (state_nxt == S_LOCK);
    end
  end

endmodule

// File: tb/tb_key_load_ctrl.sv
// Directed bench for key_load_ctrl: clean/gapped loads, parity and timeout
// failures, lockout, reload from RUN and reset during a frame.
module tb_key_load_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_req = 1'b0;
  logic       key_sdi = 1'b0;
  logic       key_sdi_vld = 1'b0;
  logic       core_rst, key_valid, load_ack, busy, par_err, timeout_err, lockout;
  logic [7:0] key_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic busy_dropped;
  logic ack_seen;

  key_load_ctrl #(.KEY_W(8), .LOAD_TO(64), .MAX_FAIL(3)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .key_sdi(key_sdi),
    .key_sdi_vld(key_sdi_vld), .core_rst(core_rst), .key_out(key_out),
    .key_valid(key_valid), .load_ack(load_ack), .busy(busy),
    .par_err(par_err), .timeout_err(timeout_err), .lockout(lockout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (!busy) busy_dropped = 1'b1;
    if (load_ack) ack_seen = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends the first nbits of frame LSB-first, with gap idle cycles before each bit.
  task automatic send_bits(input logic [8:0] frame, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) begin
      key_sdi_vld = 1'b0;
      repeat (gap) tick();
      key_sdi_vld = 1'b1;
      key_sdi     = frame[i];
      tick();
    end
    key_sdi_vld = 1'b0;
    key_sdi     = 1'b0;
  endtask

  task automatic start_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic parity_fail(input string tag, input logic exp_lock);
    start_load();
    send_bits({1'b1, 8'h3C}, 9, 0);
    tick();
    check({tag, "_par_err"}, par_err, 1'b1);
    check({tag, "_lockout"}, lockout, exp_lock);
  endtask

  initial begin
    int n;

    // reset values
    do_reset();
    check("rst_core_rst", core_rst, 1'b1);
    check("rst_key_out", key_out, 8'h00);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_outputs", {load_ack, busy, par_err, timeout_err, lockout}, 5'b0);

    // clean load of 0xA5
    start_load();
    check("clean_busy_shift", busy, 1'b1);
    ack_seen = 1'b0;
    send_bits({1'b0, 8'hA5}, 9, 0);
    check("clean_check_busy", busy, 1'b1);
    check("clean_no_valid_yet", key_valid, 1'b0);
    check("clean_no_ack_early", ack_seen, 1'b0);
    tick();
    check("clean_key_out", key_out, 8'hA5);
    check("clean_key_valid", key_valid, 1'b1);
    check("clean_load_ack", load_ack, 1'b1);
    check("clean_core_rst_e1", core_rst, 1'b1);
    tick();
    check("clean_ack_pulse", load_ack, 1'b0);
    check("clean_core_rst_e2", core_rst, 1'b0);
    check("clean_busy_run", busy, 1'b0);
    repeat (3) tick();
    check("clean_key_stable", key_out, 8'hA5);
    check("clean_core_run", core_rst, 1'b0);

    // gapped load, 3 idle cycles before each bit
    do_reset();
    start_load();
    busy_dropped = 1'b0;
    send_bits({1'b0, 8'hA5}, 9, 3);
    check("gap_busy_held", busy_dropped, 1'b0);
    tick();
    check("gap_key_out", key_out, 8'hA5);
    check("gap_key_valid", key_valid, 1'b1);
    tick();
    check("gap_core_rst", core_rst, 1'b0);

    // parity error, then recovery clears fail count
    do_reset();
    parity_fail("perr1", 1'b0);
    check("perr_key_valid", key_valid, 1'b0);
    check("perr_core_rst", core_rst, 1'b1);
    check("perr_idle", busy, 1'b0);
    tick();
    check("perr_pulse", par_err, 1'b0);
    parity_fail("perr2", 1'b0);
    start_load();
    send_bits({1'b0, 8'hA5}, 9, 0);
    tick();
    check("recover_valid", key_valid, 1'b1);
    tick();
    tick();
    parity_fail("perr3", 1'b0);
    check("reload_fail_key_out", key_out, 8'h00);
    parity_fail("perr4", 1'b0);

    // third consecutive failure by timeout
    start_load();
    n = 0;
    while (!timeout_err && n < 100) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, 64);
    check("timeout_lockout", lockout, 1'b1);
    check("lock_core_rst", core_rst, 1'b1);
    check("lock_busy", busy, 1'b0);
    tick();
    check("timeout_pulse", timeout_err, 1'b0);
    ack_seen = 1'b0;
    start_load();
    send_bits({1'b0, 8'hA5}, 9, 0);
    repeat (3) tick();
    check("lock_ignore_ack", ack_seen, 1'b0);
    check("lock_ignore_valid", key_valid, 1'b0);
    check("lock_key_out", key_out, 8'h00);
    check("lock_held", lockout, 1'b1);
    do_reset();
    check("lock_rst_clear", lockout, 1'b0);

    // reload from RUN
    start_load();
    send_bits({1'b0, 8'hA5}, 9, 0);
    tick();
    tick();
    check("reload_pre_run", core_rst, 1'b0);
    start_load();
    check("reload_core_rst", core_rst, 1'b1);
    check("reload_key_clr", key_out, 8'h00);
    check("reload_valid_clr", key_valid, 1'b0);
    check("reload_busy", busy, 1'b1);
    send_bits({1'b0, 8'h0F}, 9, 0);
    tick();
    check("reload_key_out", key_out, 8'h0F);
    tick();
    check("reload_core_run", core_rst, 1'b0);

    // reset in the middle of a frame
    do_reset();
    start_load();
    send_bits({1'b0, 8'hA5}, 4, 0);
    do_reset();
    check("midrst_busy", busy, 1'b0);
    check("midrst_core_rst", core_rst, 1'b1);
    check("midrst_outputs", {key_valid, load_ack, par_err, timeout_err, lockout}, 5'b0);
    start_load();
    send_bits({1'b0, 8'hC3}, 9, 0);
    tick();
    check("midrst_key_out", key_out, 8'hC3);
    check("midrst_par_ok", par_err, 1'b0);
    tick();
    check("midrst_core_run", core_rst, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
